// File: rtl/lm_sm_sequencer.sv
// lm_sm_sequencer: handshaked register/memory address stepper for LM/SM multi-register transfers
module lm_sm_sequencer #(
   parameter int ADDR_W = 16,
   parameter int RA_W   = 3
) (
   input  logic              clk,
   input  logic              proc_rst,
   input  logic              start,
   input  logic [7:0]        mask,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              step_ack,
   output logic              busy,
   output logic              xfer_valid,
   output logic [RA_W-1:0]   reg_addr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        xfer_count,
   output logic              done
);
   typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
   state_t            state;
   logic [7:0]        pending;
   logic [7:0]        remaining;
   logic [ADDR_W-1:0] base;
   logic [3:0]        count_next;
   logic [RA_W-1:0]   first_of_mask;
   logic [RA_W-1:0]   first_of_remaining;
   function automatic logic [RA_W-1:0] lowest(input logic [7:0] m);
      logic [RA_W-1:0] idx;
      idx = '0;
      for (int i = 7; i >= 0; i--)
         if (m[i]) idx = RA_W'(i);
      return idx;
   endfunction
   // Candidates for the next transfer: mask with the current register retired, and the bumped count
   always_comb begin
      remaining          = pending & ~(8'd1 << reg_addr);
      count_next         = xfer_count + 4'd1;
      first_of_mask      = lowest(mask);
      first_of_remaining = lowest(remaining);
   end
   // Sequencer FSM; every output is registered here
   always_ff @(posedge clk or posedge proc_rst) begin
      if (proc_rst) begin
         state      <= IDLE;
         pending    <= '0;
         base       <= '0;
         busy       <= 1'b0;
         xfer_valid <= 1'b0;
         reg_addr   <= '0;
         mem_addr   <= '0;
         xfer_count <= '0;
         done       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               busy       <= 1'b0;
               xfer_valid <= 1'b0;
               done       <= 1'b0;
               if (start) begin
                  pending    <= mask;
                  base       <= base_addr;
                  xfer_count <= '0;
                  busy       <= 1'b1;
                  if (mask != 8'd0) begin
                     state      <= XFER;
                     xfer_valid <= 1'b1;
                     reg_addr   <= first_of_mask;
                     mem_addr   <= base_addr;
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end
            XFER: begin
               if (step_ack) begin
                  pending    <= remaining;
                  xfer_count <= count_next;
                  if (remaining != 8'd0) begin
                     reg_addr <= first_of_remaining;
                     mem_addr <= base + {{(ADDR_W-4){1'b0}}, count_next};
                  end else begin
                     state      <= DONE;
                     xfer_valid <= 1'b0;
                     done       <= 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_lm_sm_sequencer.sv
// tb_lm_sm_sequencer: randomized self-checking bench for lm_sm_sequencer against a transfer-list model
module tb_lm_sm_sequencer;
   logic        clk = 1'b0;
   logic        proc_rst;
   logic        start;
   logic [7:0]  mask;
   logic [15:0] base_addr;
   logic        step_ack;
   logic        busy;
   logic        xfer_valid;
   logic [2:0]  reg_addr;
   logic [15:0] mem_addr;
   logic [3:0]  xfer_count;
   logic        done;
   logic [25:0] obs;
   int          total = 0;
   int          passed = 0;
   logic [2:0]  last_reg = 3'd0;
   logic [15:0] last_mem = 16'd0;

   lm_sm_sequencer #(.ADDR_W(16), .RA_W(3)) dut (
      .clk(clk), .proc_rst(proc_rst), .start(start), .mask(mask), .base_addr(base_addr),
      .step_ack(step_ack), .busy(busy), .xfer_valid(xfer_valid), .reg_addr(reg_addr),
      .mem_addr(mem_addr), .xfer_count(xfer_count), .done(done)
   );

   always #5 clk = ~clk;
   assign obs = {busy, xfer_valid, done, reg_addr, mem_addr, xfer_count};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one start..done sequence; ack_pct<0 alternates ack 0/1, otherwise random with that percentage
   task automatic run_sequence(input logic [7:0] m, input logic [15:0] b, input int ack_pct, input string tag);
      logic [2:0]  q_reg[$];
      logic [15:0] q_mem[$];
      logic [25:0] exp;
      int k;
      int cycles;
      bit ack;
      for (int i = 0; i < 8; i++)
         if (m[i]) begin
            q_mem.push_back(b + 16'(q_reg.size()));
            q_reg.push_back(3'(i));
         end
      start = 1'b1; mask = m; base_addr = b;
      tick();
      start = 1'b0; mask = $urandom; base_addr = $urandom;
      k = 0; cycles = 0;
      while (k < q_reg.size() && cycles < 200) begin
         exp = {1'b1, 1'b1, 1'b0, q_reg[k], q_mem[k], 4'(k)};
         total++;
         if (obs !== exp) $display("FAIL %s xfer %0d cycle %0d: got %h want %h", tag, k, cycles, obs, exp);
         else passed++;
         ack = (ack_pct < 0) ? bit'(cycles % 2) : ($urandom_range(99) < ack_pct);
         step_ack = ack;
         tick();
         step_ack = 1'b0;
         if (ack) k++;
         cycles++;
      end
      if (cycles >= 200) begin
         total++;
         $display("FAIL %s timeout: transfers %0d of %0d", tag, k, q_reg.size());
      end
      if (ack_pct == 100) begin
         total++;
         if (cycles != q_reg.size()) $display("FAIL %s latency: got %0d want %0d", tag, cycles, q_reg.size());
         else passed++;
      end
      if (q_reg.size() > 0) begin
         last_reg = q_reg[q_reg.size()-1];
         last_mem = q_mem[q_mem.size()-1];
      end
      exp = {1'b1, 1'b0, 1'b1, last_reg, last_mem, 4'(q_reg.size())};
      total++;
      if (obs !== exp) $display("FAIL %s done: got %h want %h", tag, obs, exp);
      else passed++;
      step_ack = $urandom_range(1);
      tick();
      step_ack = 1'b0;
      exp = {1'b0, 1'b0, 1'b0, last_reg, last_mem, 4'(q_reg.size())};
      total++;
      if (obs !== exp) $display("FAIL %s idle: got %h want %h", tag, obs, exp);
      else passed++;
   endtask

   task automatic test_reset();
      proc_rst = 1'b0; start = 1'b0; mask = 8'h00; base_addr = 16'h0000; step_ack = 1'b0;
      #2 proc_rst = 1'b1;
      #1;
      total++;
      if (obs !== 26'd0) $display("FAIL reset_async: got %h want 0", obs);
      else passed++;
      start = 1'b1; mask = 8'hFF; step_ack = 1'b1;
      tick();
      tick();
      total++;
      if (obs !== 26'd0) $display("FAIL reset_hold: got %h want 0", obs);
      else passed++;
      start = 1'b0; step_ack = 1'b0; proc_rst = 1'b0;
      tick();
      total++;
      if (obs !== 26'd0) $display("FAIL reset_release: got %h want 0", obs);
      else passed++;
   endtask

   task automatic test_basic();
      run_sequence(8'b1010_0101, 16'h0040, 100, "basic");
   endtask

   task automatic test_zero_mask();
      run_sequence(8'h00, 16'h1234, 100, "zero_mask");
   endtask

   task automatic test_wrap();
      run_sequence(8'hFF, 16'hFFFE, -1, "wrap");
   endtask

   task automatic test_ignore();
      logic [25:0] exp;
      start = 1'b1; mask = 8'h81; base_addr = 16'h0100;
      tick();
      start = 1'b0;
      exp = {1'b1, 1'b1, 1'b0, 3'd0, 16'h0100, 4'd0};
      total++;
      if (obs !== exp) $display("FAIL ignore_r0: got %h want %h", obs, exp);
      else passed++;
      step_ack = 1'b1;
      tick();
      exp = {1'b1, 1'b1, 1'b0, 3'd7, 16'h0101, 4'd1};
      total++;
      if (obs !== exp) $display("FAIL ignore_r7: got %h want %h", obs, exp);
      else passed++;
      tick();
      exp = {1'b1, 1'b0, 1'b1, 3'd7, 16'h0101, 4'd2};
      total++;
      if (obs !== exp) $display("FAIL ignore_done: got %h want %h", obs, exp);
      else passed++;
      start = 1'b1; mask = 8'hFF; base_addr = 16'h0000;
      tick();
      start = 1'b0;
      exp = {1'b0, 1'b0, 1'b0, 3'd7, 16'h0101, 4'd2};
      total++;
      if (obs !== exp) $display("FAIL ignore_start_in_done: got %h want %h", obs, exp);
      else passed++;
      tick();
      total++;
      if (obs !== exp) $display("FAIL ignore_ack_in_idle: got %h want %h", obs, exp);
      else passed++;
      step_ack = 1'b0;
      last_reg = 3'd7; last_mem = 16'h0101;
   endtask

   task automatic test_abort();
      logic [15:0] b;
      logic [25:0] exp;
      b = 16'($urandom);
      start = 1'b1; mask = 8'h0F; base_addr = b;
      tick();
      start = 1'b0; step_ack = 1'b1;
      tick();
      tick();
      step_ack = 1'b0;
      exp = {1'b1, 1'b1, 1'b0, 3'd2, b + 16'd2, 4'd2};
      total++;
      if (obs !== exp) $display("FAIL abort_before: got %h want %h", obs, exp);
      else passed++;
      proc_rst = 1'b1;
      #1;
      total++;
      if (obs !== 26'd0) $display("FAIL abort_async: got %h want 0", obs);
      else passed++;
      tick();
      proc_rst = 1'b0;
      tick();
      total++;
      if (obs !== 26'd0) $display("FAIL abort_no_done: got %h want 0", obs);
      else passed++;
      last_reg = 3'd0; last_mem = 16'd0;
      run_sequence(8'h10, 16'($urandom), 100, "after_abort");
   endtask

   task automatic test_back_to_back();
      logic [15:0] b;
      logic [25:0] exp;
      int ph;
      b = 16'($urandom);
      start = 1'b1; mask = 8'h03; base_addr = b; step_ack = 1'b1;
      for (int c = 0; c < 12; c++) begin
         tick();
         ph = c % 4;
         exp = (ph == 0) ? {1'b1, 1'b1, 1'b0, 3'd0, b, 4'd0} :
               (ph == 1) ? {1'b1, 1'b1, 1'b0, 3'd1, b + 16'd1, 4'd1} :
               (ph == 2) ? {1'b1, 1'b0, 1'b1, 3'd1, b + 16'd1, 4'd2} :
                           {1'b0, 1'b0, 1'b0, 3'd1, b + 16'd1, 4'd2};
         total++;
         if (obs !== exp) $display("FAIL back_to_back cycle %0d: got %h want %h", c, obs, exp);
         else passed++;
      end
      start = 1'b0; step_ack = 1'b0;
      tick();
      last_reg = 3'd1; last_mem = b + 16'd1;
   endtask

   task automatic test_random();
      for (int n = 0; n < 12; n++)
         run_sequence((n % 4 == 3) ? 8'h00 : 8'($urandom), 16'($urandom), 30 + $urandom_range(70), "random");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_mask();
      test_wrap();
      test_ignore();
      test_abort();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/lm_sm_sequencer.md
# lm_sm_sequencer

Multi-register transfer sequencer for the LM/SM (load-multiple / store-multiple) instructions. It takes the 8-bit register mask from IR[7:0] and a base memory address, and presents one register-file address / memory address pair per transfer. It advances only when the datapath acknowledges each transfer. It sits between the main controller and the register file / memory address mux, replacing the controller's counter and mask-clearing loop with a handshaked stepping engine.

## Interface
- ADDR_W, 16, width of memory addresses and base address
- RA_W, 3, width of register-file addresses (8 registers)
- clk  input  1  system clock; all state changes on rising edge
- proc_rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request; sampled only in IDLE
- mask  input  8  register mask; bit i set means transfer register i; sampled with start
- base_addr  input  ADDR_W  memory address of the first transfer; sampled with start
- step_ack  input  1  datapath has completed the current transfer; meaningful only while xfer_valid=1
- busy  output  1  high in XFER and DONE
- xfer_valid  output  1  reg_addr/mem_addr hold a valid transfer
- reg_addr  output  RA_W  register index of the current transfer
- mem_addr  output  ADDR_W  base_addr + xfer_count, modulo 2^ADDR_W
- xfer_count  output  4  number of transfers already acknowledged (0..8)
- done  output  1  one-cycle pulse when the sequence completes

## Operation
- States: IDLE, XFER, DONE. Reset value is IDLE. All outputs are registered.
- Output reset values: busy=0, xfer_valid=0, reg_addr=0, mem_addr=0, xfer_count=0, done=0. Internal pending mask=0, base=0.
- IDLE with start=1:
  - Latch mask into pending and base_addr into base. Clear xfer_count.
  - If mask≠0: go to XFER. reg_addr = index of the lowest set bit of mask. mem_addr = base_addr.
  - If mask=0: go directly to DONE. No transfer is issued.
- IDLE with start=0: hold. Outputs keep their last values except xfer_valid=0, busy=0, done=0.
- XFER: xfer_valid=1, busy=1.
  - On step_ack=1, clear bit reg_addr in pending and increment xfer_count.
  - If the remaining pending≠0: stay in XFER. reg_addr = lowest remaining set bit. mem_addr = base + new xfer_count.
  - If the remaining pending=0: go to DONE. reg_addr and mem_addr hold their last values.
  - step_ack=0: hold every output unchanged.
- DONE: done=1, busy=1, xfer_valid=0 for exactly one cycle, then return to IDLE.
- start outside IDLE is ignored. A start in the DONE cycle is also ignored.
- step_ack outside XFER is ignored.
- Priority selection: the lowest-numbered set bit is transferred first (R0 before R7).
- Address arithmetic:
  - mem_addr = base + zero-extended xfer_count, truncated to ADDR_W.
  - base=16'hFFFE, 3 transfers gives 16'hFFFE, 16'hFFFF, 16'h0000.
- Mask 8'hFF gives 8 transfers. xfer_count reaches 8 and is reported in DONE.
- proc_rst asserted at any time, including mid-sequence, forces IDLE and the reset values immediately. No done pulse is generated for an aborted sequence.

## Timing
- start at cycle n (mask≠0): xfer_valid=1 at n+1 with the first reg_addr/mem_addr.
- start at cycle n (mask=0): done=1 at n+1. busy falls at n+2.
- step_ack at cycle k (not the last transfer): the next transfer is presented at k+1. xfer_valid stays high, so back-to-back acks give one transfer per cycle.
- Last step_ack at cycle k: xfer_valid=0 and done=1 at k+1, IDLE at k+2.
- Earliest restart is start at k+2 (first IDLE cycle).
- Total latency with continuous acks and N set bits: start to done is N+1 cycles.
- Reset is asynchronous on assertion. Release is sampled on the next rising clk; the first start accepted is on or after the first edge with proc_rst=0.

## Test plan
- mask=8'b1010_0101, base=16'h0040, step_ack held 1 -> reg_addr 0,2,5,7 with mem_addr 0040,0041,0042,0043 on consecutive cycles. done at start+5. xfer_count=4.
- mask=8'h00, base=16'h1234 -> xfer_valid never rises. done pulses one cycle after start. xfer_count=0.
- mask=8'hFF, base=16'hFFFE, step_ack toggling 0/1 -> 8 transfers. mem_addr wraps FFFE,FFFF,0000..0005. Each transfer is held stable while step_ack=0. Final xfer_count=8.
- mask=8'h81, second start and stray step_ack issued during DONE and IDLE -> only R0 then R7 are transferred. The extra start is ignored. No spurious xfer_count change.
- mask=8'h0F, proc_rst asserted for 1 cycle after the 2nd ack -> all outputs reset asynchronously with no done pulse. A fresh start with mask=8'h10 then yields a single transfer, reg_addr=4.
- start held high continuously, mask=8'h03 -> sequences run back-to-back: done, then IDLE, then a restart every 4 cycles.
